// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the data-memory responder.
//   mem_size_e  - access size field carried on mem_size
//   mem_state_e - responder FSM states
//   RW_LOAD / RW_STORE - mem_rw encodings
//   is_misaligned() - alignment / reserved-size check used by the lane logic
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  // Reserved size is reported the same way as a misaligned access.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return |offset;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bundle between the EX/MEM pipeline
// register (master) and the data-memory responder (slave).
//   mem_enable/mem_rw/mem_size/mem_se/mem_addr/mem_wdata : request, master -> slave
//   mem_rdata/mem_ready/mem_err/mem_stall                : response, slave -> master
interface data_mem_responder_if;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_se;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_stall;
  logic        mem_err;

  modport master (
    output mem_enable, mem_rw, mem_size, mem_se, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_stall, mem_err
  );

  modport slave (
    input  mem_enable, mem_rw, mem_size, mem_se, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_stall, mem_err
  );
endinterface

// File: rtl/mem_align.sv
// mem_align: combinational big-endian lane logic.
//   size, se, offset : access size, sign-extend flag, address bits [1:0]
//   rd_word          : the aligned RAM word containing the access (byte A -> [31:24])
//   wdata            : right-justified store data
//   load_data        : extracted and extended load result (0 on error)
//   byte_en          : store byte enables, bit 3 = offset 0 (0 on error)
//   wr_word          : store data replicated onto every lane
//   err              : misaligned access or reserved size
module mem_align
  import mem_pkg::*;
(
  input  mem_size_e   size,
  input  logic        se,
  input  logic [1:0]  offset,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic        err
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    load_data = '0;
    byte_en   = '0;
    wr_word   = '0;
    err       = is_misaligned(size, offset);

    case (offset)
      2'd0:    lane_b = rd_word[31:24];
      2'd1:    lane_b = rd_word[23:16];
      2'd2:    lane_b = rd_word[15:8];
      default: lane_b = rd_word[7:0];
    endcase
    lane_h = offset[1] ? rd_word[15:0] : rd_word[31:16];

    if (!err) begin
      case (size)
        SZ_BYTE: begin
          load_data = {{24{se & lane_b[7]}}, lane_b};
          wr_word   = {4{wdata[7:0]}};
          byte_en   = 4'b1000 >> offset;
        end
        SZ_HALF: begin
          load_data = {{16{se & lane_h[15]}}, lane_h};
          wr_word   = {2{wdata[15:0]}};
          byte_en   = offset[1] ? 4'b0011 : 4'b1100;
        end
        SZ_WORD: begin
          load_data = rd_word;
          wr_word   = wdata;
          byte_en   = 4'b1111;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory with fixed programmable latency.
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : slave side of data_mem_responder_if (request in, rdata/ready/err/stall out)
// A request is captured in IDLE, completes LATENCY cycles later with a
// one-cycle mem_ready in DONE, and a store commits on the edge leaving DONE.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  // NOTE: the RAM has no reset branch; clearing it would need a per-entry
  // write loop and its contents are defined only by stores.
  logic [7:0] ram [2**ADDR_W];

  mem_state_e        state, next_state;
  logic [3:0]        cnt;
  logic              rw_q, se_q;
  mem_size_e         size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  // Request seen by the lane logic: live inputs while IDLE, captured copy after.
  logic              cur_rw, cur_se;
  mem_size_e         cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [ADDR_W-1:0] lane_addr [4];
  logic [31:0]       rd_word, load_data, wr_word;
  logic [3:0]        byte_en;
  logic              align_err;
  logic              entering_done;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.mem_addr[31:ADDR_W];

  always_comb begin
    if (state == ST_IDLE) begin
      cur_rw    = bus.mem_rw;
      cur_se    = bus.mem_se;
      cur_size  = mem_size_e'(bus.mem_size);
      cur_addr  = bus.mem_addr[ADDR_W-1:0];
      cur_wdata = bus.mem_wdata;
    end else begin
      cur_rw    = rw_q;
      cur_se    = se_q;
      cur_size  = size_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign lane_addr[g] = {cur_addr[ADDR_W-1:2], 2'(g)};
  end

  assign rd_word = {ram[lane_addr[0]], ram[lane_addr[1]], ram[lane_addr[2]], ram[lane_addr[3]]};

  mem_align u_align (
    .size     (cur_size),
    .se       (cur_se),
    .offset   (cur_addr[1:0]),
    .rd_word  (rd_word),
    .wdata    (cur_wdata),
    .load_data(load_data),
    .byte_en  (byte_en),
    .wr_word  (wr_word),
    .err      (align_err)
  );

  // State register, latency counter and registered response.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && bus.mem_enable) cnt <= CNT_INIT;
      else if (state == ST_WAIT)              cnt <= cnt - 4'd1;
      // Response is loaded on the edge into DONE and cleared on the edge out.
      rdata_q <= (entering_done && !align_err && cur_rw == RW_LOAD) ? load_data : '0;
      err_q   <= entering_done && align_err;
    end
  end

  // Captured request; only meaningful between acceptance and DONE.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.mem_enable) begin
      rw_q    <= bus.mem_rw;
      se_q    <= bus.mem_se;
      size_q  <= mem_size_e'(bus.mem_size);
      addr_q  <= bus.mem_addr[ADDR_W-1:0];
      wdata_q <= bus.mem_wdata;
    end
  end

  // Store commit on the edge leaving DONE; a reset in DONE aborts it.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_DONE && rw_q == RW_STORE && !align_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[3-i]) ram[lane_addr[i]] <= wr_word[8*(3-i) +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.mem_enable) next_state = (LATENCY == 1) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (cnt <= 4'd1) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign entering_done = (next_state == ST_DONE) && (state != ST_DONE);

  // Outputs.
  always_comb begin
    bus.mem_ready = (state == ST_DONE);
    bus.mem_rdata = rdata_q;
    bus.mem_err   = err_q;
    bus.mem_stall = bus.mem_enable & (state != ST_DONE);
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven loads/stores on a LATENCY=2 instance,
// reset-abort and back-to-back sequences on LATENCY=2 / LATENCY=1 instances.
// Expected responses are queued when a request is driven and compared when
// the DUT pulses mem_ready.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if bif2 ();
  data_mem_responder_if bif1 ();

  data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bif2));
  data_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bif1));

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        se;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [1:0] size, input logic se,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input string name);
    vec_t v;
    v.rw = rw; v.size = size; v.se = se; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    return v;
  endfunction

  task automatic drive(input int which, input vec_t v, input logic en);
    if (which == 1) begin
      bif1.mem_enable = en; bif1.mem_rw = v.rw; bif1.mem_size = v.size;
      bif1.mem_se = v.se; bif1.mem_addr = v.addr; bif1.mem_wdata = v.wdata;
    end else begin
      bif2.mem_enable = en; bif2.mem_rw = v.rw; bif2.mem_size = v.size;
      bif2.mem_se = v.se; bif2.mem_addr = v.addr; bif2.mem_wdata = v.wdata;
    end
  endtask

  function automatic logic rdy(input int which);
    return (which == 1) ? bif1.mem_ready : bif2.mem_ready;
  endfunction

  function automatic logic stl(input int which);
    return (which == 1) ? bif1.mem_stall : bif2.mem_stall;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.is_load = (v.rw == RW_LOAD); e.rdata = v.exp_rdata; e.err = v.exp_err; e.name = v.name;
    return e;
  endfunction

  // Starts in an IDLE cycle at posedge+1; returns at posedge+1 of the following IDLE cycle.
  task automatic access(input int which, input vec_t v);
    int   waited;
    logic got;
    drive(which, v, 1'b1);
    if (which == 1) q1.push_back(to_exp(v)); else q2.push_back(to_exp(v));
    #1;
    check({v.name, " stall@T"}, 64'(stl(which)), 64'(1));
    #1;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 20) begin
      @(posedge clk); #1;
      waited++;
      if (rdy(which)) got = 1'b1;
      else check({v.name, " stall"}, 64'(stl(which)), 64'(1));
    end
    check({v.name, " latency"}, 64'(waited), 64'((which == 1) ? 1 : 2));
    drive(which, mk(0, 0, 0, 0, 0, 0, 0, ""), 1'b0);
    @(posedge clk); #1;
  endtask

  // Response monitors: compare at ready, and outputs must be zero otherwise.
  exp_t m1_e, m2_e;
  always @(negedge clk) begin
    if (bif2.mem_ready) begin
      if (q2.size() == 0) check("dut2 unexpected ready", 64'(1), 64'(0));
      else begin
        m2_e = q2.pop_front();
        if (m2_e.is_load) check({m2_e.name, " rdata"}, 64'(bif2.mem_rdata), 64'(m2_e.rdata));
        check({m2_e.name, " err"}, 64'(bif2.mem_err), 64'(m2_e.err));
      end
    end else begin
      check("dut2 idle outputs", 64'({bif2.mem_err, bif2.mem_rdata}), 64'(0));
    end
    if (bif1.mem_ready) begin
      if (q1.size() == 0) check("dut1 unexpected ready", 64'(1), 64'(0));
      else begin
        m1_e = q1.pop_front();
        if (m1_e.is_load) check({m1_e.name, " rdata"}, 64'(bif1.mem_rdata), 64'(m1_e.rdata));
        check({m1_e.name, " err"}, 64'(bif1.mem_err), 64'(m1_e.err));
      end
    end else begin
      check("dut1 idle outputs", 64'({bif1.mem_err, bif1.mem_rdata}), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[16];
  vec_t bb[4];
  vec_t idle_v;

  initial begin
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, "");
    vecs[0]  = mk(RW_STORE, SZ_WORD, 0, 32'h10,  32'hDEADBEEF, 0,            0, "st_w_10");
    vecs[1]  = mk(RW_LOAD,  SZ_WORD, 0, 32'h10,  0,            32'hDEADBEEF, 0, "ld_w_10");
    vecs[2]  = mk(RW_LOAD,  SZ_BYTE, 1, 32'h11,  0,            32'hFFFFFFAD, 0, "ld_b_11_se");
    vecs[3]  = mk(RW_LOAD,  SZ_BYTE, 0, 32'h11,  0,            32'h000000AD, 0, "ld_b_11_ze");
    vecs[4]  = mk(RW_LOAD,  SZ_HALF, 1, 32'h12,  0,            32'hFFFFBEEF, 0, "ld_h_12_se");
    vecs[5]  = mk(RW_LOAD,  SZ_HALF, 0, 32'h10,  0,            32'h0000DEAD, 0, "ld_h_10_ze");
    vecs[6]  = mk(RW_STORE, SZ_BYTE, 0, 32'h13,  32'hAAAAAA55, 0,            0, "st_b_13");
    vecs[7]  = mk(RW_LOAD,  SZ_WORD, 0, 32'h10,  0,            32'hDEADBE55, 0, "ld_w_after_sb");
    vecs[8]  = mk(RW_LOAD,  SZ_WORD, 0, 32'h12,  0,            32'h0,        1, "ld_w_misalign");
    vecs[9]  = mk(RW_STORE, SZ_HALF, 0, 32'h11,  32'h0000FFFF, 0,            1, "st_h_misalign");
    vecs[10] = mk(RW_LOAD,  SZ_WORD, 0, 32'h10,  0,            32'hDEADBE55, 0, "ld_w_unchanged");
    vecs[11] = mk(RW_LOAD,  SZ_RSVD, 0, 32'h10,  0,            32'h0,        1, "ld_rsvd_size");
    vecs[12] = mk(RW_STORE, SZ_HALF, 1, 32'h12,  32'h1234CAFE, 0,            0, "st_h_12");
    vecs[13] = mk(RW_LOAD,  SZ_WORD, 0, 32'h110, 0,            32'hDEADCAFE, 0, "ld_w_wrap");
    vecs[14] = mk(RW_LOAD,  SZ_BYTE, 1, 32'h12,  0,            32'hFFFFFFCA, 0, "ld_b_12_se");
    vecs[15] = mk(RW_LOAD,  SZ_HALF, 0, 32'h13,  0,            32'h0,        1, "ld_h_misalign");

    bb[0] = mk(RW_LOAD, SZ_WORD, 0, 32'h00, 0, 32'h11223344, 0, "bb_ld_w_00");
    bb[1] = mk(RW_LOAD, SZ_BYTE, 1, 32'h04, 0, 32'hFFFFFFA5, 0, "bb_ld_b_04");
    bb[2] = mk(RW_LOAD, SZ_HALF, 0, 32'h02, 0, 32'h00003344, 0, "bb_ld_h_02");
    bb[3] = mk(RW_LOAD, SZ_BYTE, 0, 32'h01, 0, 32'h00000022, 0, "bb_ld_b_01");

    // Reset state.
    reset = 1'b1;
    drive(1, idle_v, 1'b0);
    drive(2, idle_v, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset ready",  64'(bif2.mem_ready), 64'(0));
    check("reset err",    64'(bif2.mem_err),   64'(0));
    check("reset rdata",  64'(bif2.mem_rdata), 64'(0));
    check("reset stall0", 64'(bif2.mem_stall), 64'(0));
    bif2.mem_enable = 1'b1;
    #1;
    check("reset stall1", 64'(bif2.mem_stall), 64'(1));
    bif2.mem_enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven accesses on the LATENCY=2 instance.
    for (int i = 0; i < 16; i++) access(2, vecs[i]);

    // Reset while a store is in WAIT: no ready, store not committed.
    drive(2, mk(RW_STORE, SZ_WORD, 0, 32'h10, 32'h12345678, 0, 0, ""), 1'b1);
    @(posedge clk); #1;
    check("abort in WAIT stall", 64'(bif2.mem_stall), 64'(1));
    reset = 1'b1;
    drive(2, idle_v, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort no ready", 64'(bif2.mem_ready), 64'(0));
    end
    reset = 1'b0;
    @(posedge clk); #1;
    access(2, mk(RW_LOAD, SZ_WORD, 0, 32'h10, 0, 32'hDEADCAFE, 0, "ld_after_abort"));

    // Back-to-back loads on the LATENCY=1 instance with mem_enable held.
    access(1, mk(RW_STORE, SZ_WORD, 0, 32'h00, 32'h11223344, 0, 0, "l1_st_w_00"));
    access(1, mk(RW_STORE, SZ_WORD, 0, 32'h04, 32'hA5A5A5A5, 0, 0, "l1_st_w_04"));
    drive(1, bb[0], 1'b1);
    q1.push_back(to_exp(bb[0]));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check({bb[k].name, " ready pulse"}, 64'(bif1.mem_ready), 64'(1));
      if (k < 3) begin
        drive(1, bb[k+1], 1'b1);
        q1.push_back(to_exp(bb[k+1]));
      end else begin
        drive(1, idle_v, 1'b0);
      end
      @(posedge clk); #1;
      check({bb[k].name, " ready gap"}, 64'(bif1.mem_ready), 64'(0));
    end

    repeat (2) @(posedge clk);
    #1;
    check("dut2 queue drained", 64'(q2.size()), 64'(0));
    check("dut1 queue drained", 64'(q1.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
